// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial WIDTH-bit adder sequencer. A full-adder slice is built from two
//   half_adder cells plus an OR. The operands are latched and stepped through
//   the slice LSB-first, one bit per clock. The carry is held in a flop between
//   bits. The sum and carry-out are returned over a valid/ready handshake.
//
//   Optional feature macro: SERIAL_ADD_SUB_EN
//     When defined, the sub port exists. With sub=1 the block computes op_a - op_b
//     by inverting B into the slice and presetting the carry flop to 1.
//
//   Parameters
//     WIDTH      operand/result width, 2..32
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     in_valid   operands valid          in_ready  block can accept operands
//     op_a/op_b  operands                sub       subtract select (macro only)
//     out_valid  result/cout valid       out_ready consumer accepts result
//     result     sum/difference bits     cout      carry-out of the MSB
//     busy       high whenever the sequencer is not idle
// -----------------------------------------------------------------------------

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;

  // Bit of B presented to the slice (inverted when subtracting).
  logic b_bit;
`ifdef SERIAL_ADD_SUB_EN
  logic sub_reg;
  assign b_bit = b_reg[0] ^ sub_reg;
`else
  assign b_bit = b_reg[0];
`endif

  // Full-adder slice: two half adders, the carries ORed together.
  logic ha0_sum;
  logic ha0_carry;
  logic sum_bit;
  logic ha1_carry;
  logic carry_next;

  half_adder u_ha0 (
    .a     (a_reg[0]),
    .b     (b_bit),
    .sum   (ha0_sum),
    .carry (ha0_carry)
  );

  half_adder u_ha1 (
    .a     (ha0_sum),
    .b     (carry_reg),
    .sum   (sum_bit),
    .carry (ha1_carry)
  );

  assign carry_next = ha0_carry | ha1_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      result_reg    <= '0;
      cnt_reg       <= '0;
      carry_reg     <= 1'b0;
      cout_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= op_a;
            b_reg        <= op_b;
            cnt_reg      <= '0;
`ifdef SERIAL_ADD_SUB_EN
            sub_reg      <= sub;
            // Two's-complement subtract: A + ~B + 1, the +1 enters as carry-in.
            carry_reg    <= sub;
`else
            carry_reg    <= 1'b0;
`endif
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= RUN;
          end
        end

        RUN: begin
          a_reg      <= a_reg >> 1;
          b_reg      <= b_reg >> 1;
          carry_reg  <= carry_next;
          // Sum bits enter from the MSB side so bit 0 lands in place after WIDTH steps.
          result_reg <= {sum_bit, result_reg[WIDTH-1:1]};
          cnt_reg    <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_LAST) begin
            cout_reg      <= carry_next;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end

        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign result    = result_reg;
  assign cout      = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//   Self-checking bench for serial_add_ctrl (WIDTH=8). A transaction-level
//   reference model tracks whether an operation is in flight, how many clock
//   edges have passed since it was accepted, and the arithmetic answer. A
//   compare process checks every DUT output against it on each falling edge.
//   Directed operations also carry hand-computed literal expectations.
// -----------------------------------------------------------------------------

module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] op_a      = '0;
  logic [WIDTH-1:0] op_b      = '0;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub       = 1'b0;
`endif
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout t=%0t", name, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one operation in flight at most; results appear WIDTH
  // edges after acceptance and stay until the consumer takes them.
  // ---------------------------------------------------------------------------
  bit               m_active = 1'b0;
  int               m_age    = 0;
  bit               m_known  = 1'b1;
  logic [WIDTH-1:0] m_result = '0;
  logic             m_cout   = 1'b0;
  logic [WIDTH-1:0] m_pend_result = '0;
  logic             m_pend_cout   = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 1'b0;
        m_age    = 0;
        m_known  = 1'b1;
        m_result = '0;
        m_cout   = 1'b0;
      end else if (!m_active) begin
        if (in_valid) begin
          int unsigned ua;
          int unsigned ub;
          bit          is_sub;
          ua = int'(op_a);
          ub = int'(op_b);
          is_sub = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
          is_sub = sub;
`endif
          if (is_sub) begin
            m_pend_result = WIDTH'((ua - ub) % (1 << WIDTH));
            m_pend_cout   = (ua >= ub);
          end else begin
            m_pend_result = WIDTH'((ua + ub) % (1 << WIDTH));
            m_pend_cout   = ((ua + ub) >= (1 << WIDTH));
          end
          m_active = 1'b1;
          m_age    = 0;
          m_known  = 1'b0;
        end
      end else if (m_age < WIDTH) begin
        m_age++;
        if (m_age == WIDTH) begin
          m_result = m_pend_result;
          m_cout   = m_pend_cout;
          m_known  = 1'b1;
        end
      end else if (out_ready) begin
        m_active = 1'b0;
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    @(negedge clk);
    forever begin
      check("in_ready", in_ready, !m_active);
      check("busy", busy, m_active);
      check("out_valid", out_valid, (m_active && m_age >= WIDTH));
      if (m_known) begin
        check("result", result, m_result);
        check("cout", cout, m_cout);
      end
      @(negedge clk);
    end
  end

  // ---------------------------------------------------------------------------
  // One operation with literal expectations. stall = cycles out_ready is held
  // low in DONE; noise = pulse in_valid/operands while busy; hold_next = leave
  // in_valid high across the DONE->IDLE handshake.
  // ---------------------------------------------------------------------------
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                       input logic [WIDTH-1:0] er, input logic ec,
                       input int stall, input bit noise, input bit hold_next);
    bit ok;
    int k;
    op_a = a;
    op_b = b;
`ifdef SERIAL_ADD_SUB_EN
    sub = s;
`endif
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_timeout("accept");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #2;
    in_valid = noise;
    if (noise) begin
      op_a = WIDTH'($urandom);
      op_b = WIDTH'($urandom);
    end
    ok = 1'b0;
    k  = 0;
    for (int i = 1; i <= 3 * WIDTH; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        ok = 1'b1;
        k  = i;
        break;
      end
      if (noise) begin
        in_valid = 1'($urandom);
        op_a     = WIDTH'($urandom);
      end
    end
    if (!ok) begin
      fail_timeout("out_valid");
      in_valid  = 1'b0;
      out_ready = 1'b1;
      return;
    end
    check("latency_edges", k, WIDTH);
    check("op_result", result, er);
    check("op_cout", cout, ec);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_result", result, er);
      check("stall_cout", cout, ec);
      if (noise) in_valid = 1'($urandom);
    end
    out_ready = 1'b1;
    if (hold_next) in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("out_valid_drop", out_valid, 1'b0);
    out_ready = 1'b0;
    in_valid  = hold_next;
    $display("op a=0x%02h b=0x%02h sub=%0d -> result=0x%02h cout=%0d (stall=%0d)", a, b, s, result, cout, stall);
  endtask

  task automatic reset_idle_check(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_result"}, result, 8'h00);
    check({tag, "_cout"}, cout, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. Reset then idle.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_idle_check("reset");
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_idle_check("idle");
    $display("reset/idle checked");

    // 2. Basic add with out_ready held high.
    do_op(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 0, 1'b0, 1'b0);

    // 3. Carry-out boundaries.
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0);
    do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0);

    // 4. Backpressure with in_valid noise; in_valid held into the next IDLE.
    do_op(8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 5, 1'b1, 1'b1);
    do_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0, 1'b0, 1'b0);

    // 5. Reset in the 4th RUN cycle of 0x12+0x34.
    op_a = 8'h12;
    op_b = 8'h34;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("run4_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    reset_idle_check("abort");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    $display("reset during RUN checked");
    do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 0, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    // 6. Subtract mode.
    do_op(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 0, 1'b0, 1'b0);
    do_op(8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
    do_op(8'h55, 8'h55, 1'b1, 8'h00, 1'b1, 2, 1'b0, 1'b0);
`endif

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rs;
      logic [WIDTH:0]   full;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (n % 10 == 3) ra = '1;
      if (n % 10 == 7) rb = '0;
      rs = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`endif
      if (rs) full = {1'b0, ra} - {1'b0, rb};
      else    full = {1'b0, ra} + {1'b0, rb};
      do_op(ra, rb, rs, full[WIDTH-1:0], rs ? (ra >= rb) : full[WIDTH],
            int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
    end
    in_valid = 1'b0;
    repeat (WIDTH + 4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
